// File: rtl/quant_seq_ctrl.sv
// quant_seq_ctrl: walks one feature vector through the float32 quantizer.
// For each index it reads the feature SRAM and presents the word to the
// quantizer. It captures the returned level and hands the (index, level)
// pair downstream over a valid/ready handshake. After the last pair it
// pulses done and returns to IDLE.
module quant_seq_ctrl #(
  parameter int NUM_FEATURES = 617,
  parameter int IDX_W        = 10,
  parameter int MAX_LEVEL    = 9
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start,
  input  logic             clr,
  output logic             busy,
  output logic             done,
  output logic             err_level,
  output logic             feat_rd_en,
  output logic [IDX_W-1:0] feat_rd_addr,
  input  logic [31:0]      feat_rd_data,
  output logic [31:0]      q_value,
  output logic             q_en,
  input  logic [3:0]       q_level,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [3:0]       out_level
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD   = 3'd1;
  localparam logic [2:0] LAT  = 3'd2;
  localparam logic [2:0] QNT  = 3'd3;
  localparam logic [2:0] OUT  = 3'd4;
  localparam logic [2:0] DONE = 3'd5;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_FEATURES - 1);
  localparam logic [3:0]       MAX_CODE  = 4'(MAX_LEVEL);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [IDX_W-1:0] idx;
  logic             accept;
  logic             last;
  logic             level_bad;

  assign accept    = (state == OUT) && out_ready;
  assign last      = (idx == LAST_IDX);
  assign level_bad = (q_level > MAX_CODE);

  // Next-state selection; clr overrides every other transition.
  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nxt = RD;
        RD:      state_nxt = LAT;
        LAT:     state_nxt = QNT;
        QNT:     state_nxt = OUT;
        OUT:     if (accept) state_nxt = last ? DONE : RD;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Feature index: restarts at 0 on start, clr and completion; advances on accept
  // only when more features remain, so it never wraps.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      idx <= '0;
    end else if (clr) begin
      idx <= '0;
    end else begin
      case (state)
        IDLE:    if (start) idx <= '0;
        OUT:     if (accept && !last) idx <= idx + 1'b1;
        DONE:    idx <= '0;
        default: idx <= idx;
      endcase
    end
  end

  // Quantizer input register: loaded from the SRAM data in LAT, held otherwise
  // so the combinational quantizer sees a stable value.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      q_value <= '0;
    end else if (!clr && state == LAT) begin
      q_value <= feat_rd_data;
    end
  end

  // Output pair capture in QNT; held through OUT until the next QNT.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      out_level <= '0;
      out_idx   <= '0;
    end else if (!clr && state == QNT) begin
      out_level <= q_level;
      out_idx   <= idx;
    end
  end

  // Sticky level error: cleared when a job starts, set by an out-of-range code,
  // and deliberately left untouched by clr.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      err_level <= 1'b0;
    end else if (!clr) begin
      if (state == IDLE && start) begin
        err_level <= 1'b0;
      end else if (state == QNT && level_bad) begin
        err_level <= 1'b1;
      end
    end
  end

  // Strobes decoded from the registered state, so they follow nrst immediately.
  always_comb begin
    busy         = (state != IDLE);
    done         = (state == DONE);
    feat_rd_en   = (state == RD);
    q_en         = (state == QNT);
    out_valid    = (state == OUT);
    feat_rd_addr = idx;
  end

endmodule

// File: tb/tb_quant_seq_ctrl.sv
// Scoreboard bench for quant_seq_ctrl with NUM_FEATURES=4. A behavioural SRAM
// and a lookup-table quantizer surround the DUT. The stimulus pushes the
// expected pairs and done timing. A monitor pops and compares them whenever
// the DUT hands a pair over or pulses done.
module tb_quant_seq_ctrl;

  localparam int NF = 4;
  localparam int IW = 10;

  logic          clk;
  logic          nrst;
  logic          start;
  logic          clr;
  logic          busy;
  logic          done;
  logic          err_level;
  logic          feat_rd_en;
  logic [IW-1:0] feat_rd_addr;
  logic [31:0]   feat_rd_data;
  logic [31:0]   q_value;
  logic          q_en;
  logic [3:0]    q_level;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_idx;
  logic [3:0]    out_level;

  quant_seq_ctrl #(.NUM_FEATURES(NF), .IDX_W(IW), .MAX_LEVEL(9)) dut (
    .clk(clk), .nrst(nrst), .start(start), .clr(clr), .busy(busy), .done(done),
    .err_level(err_level), .feat_rd_en(feat_rd_en), .feat_rd_addr(feat_rd_addr),
    .feat_rd_data(feat_rd_data), .q_value(q_value), .q_en(q_en), .q_level(q_level),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx), .out_level(out_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Feature SRAM: one-cycle read latency.
  logic [31:0] mem [NF];
  always @(posedge clk) begin
    if (feat_rd_en) feat_rd_data <= mem[feat_rd_addr[1:0]];
  end

  // Quantizer stand-in; the NaN word forces the illegal code 0xC.
  always_comb begin
    case (q_value)
      32'h3F800000: q_level = 4'd0;
      32'h3F000000: q_level = 4'd1;
      32'h00000000: q_level = 4'd5;
      32'hBF800000: q_level = 4'd9;
      32'h7FC00000: q_level = 4'hC;
      default:      q_level = 4'd0;
    endcase
  end

  int pc = 0;
  int base = 0;
  always @(posedge clk) pc <= pc + 1;

  typedef struct {
    int idx;
    int lvl;
    int err;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   done_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, pc - base);
    end
  endtask

  task automatic push_pair(input int i, input int l, input int e, input int c);
    exp_t x;
    x.idx = i; x.lvl = l; x.err = e; x.cyc = c;
    exp_q.push_back(x);
  endtask

  task automatic push_std(input int e2);
    push_pair(0, 0, 0, 4);
    push_pair(1, 1, 0, 8);
    push_pair(2, (e2 != 0) ? 12 : 5, e2, 12);
    push_pair(3, 9, e2, 16);
    done_q.push_back(17);
  endtask

  // Monitor: samples 2 time units after the falling edge, after inputs settle.
  initial begin
    exp_t x;
    int   c;
    forever begin
      @(negedge clk);
      #2;
      if (nrst) begin
        if (out_valid && out_ready && !clr) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_pair", 32'(out_idx), 32'hFFFF_FFFF);
          end else begin
            x = exp_q.pop_front();
            chk("pair_idx", 32'(out_idx), 32'(x.idx));
            chk("pair_level", 32'(out_level), 32'(x.lvl));
            chk("pair_err", 32'(err_level), 32'(x.err));
            chk("pair_cycle", 32'(pc - base), 32'(x.cyc));
          end
        end
        if (done) begin
          if (done_q.size() == 0) begin
            chk("unexpected_done", 32'(pc - base), 32'hFFFF_FFFF);
          end else begin
            c = done_q.pop_front();
            chk("done_cycle", 32'(pc - base), 32'(c));
          end
        end
      end
    end
  end

  task automatic start_job();
    @(negedge clk);
    base = pc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_cycle(input int c);
    while (pc - base < c) @(negedge clk);
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while (!done && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 32'(done), 32'd1);
    @(negedge clk);
  endtask

  task automatic load_std();
    mem[0] = 32'h3F800000;
    mem[1] = 32'h3F000000;
    mem[2] = 32'h00000000;
    mem[3] = 32'hBF800000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nrst = 1'b0; start = 1'b0; clr = 1'b0; out_ready = 1'b1;
    load_std();
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_rd_en", 32'(feat_rd_en), 32'd0);
    chk("rst_q_value", q_value, 32'd0);
    nrst = 1'b1;
    repeat (2) @(negedge clk);

    // 1: basic job with out_ready tied high.
    push_std(0);
    start_job();
    chk("t1_rd_en", 32'(feat_rd_en), 32'd1);
    chk("t1_rd_addr", 32'(feat_rd_addr), 32'd0);
    wait_cycle(3);
    chk("t1_q_en", 32'(q_en), 32'd1);
    chk("t1_q_value", q_value, 32'h3F800000);
    wait_done(40);
    chk("t1_idle", 32'(busy), 32'd0);

    // 2: backpressure for 5 cycles on the first pair.
    out_ready = 1'b0;
    push_pair(0, 0, 0, 9);
    push_pair(1, 1, 0, 13);
    push_pair(2, 5, 0, 17);
    push_pair(3, 9, 0, 21);
    done_q.push_back(22);
    start_job();
    wait_cycle(4);
    for (int k = 0; k < 5; k++) begin
      chk("t2_valid", 32'(out_valid), 32'd1);
      chk("t2_idx", 32'(out_idx), 32'd0);
      chk("t2_level", 32'(out_level), 32'd0);
      chk("t2_rd_en", 32'(feat_rd_en), 32'd0);
      chk("t2_q_value", q_value, 32'h3F800000);
      @(negedge clk);
    end
    out_ready = 1'b1;
    wait_done(40);

    // 3: illegal level on index 2 sets the sticky error.
    mem[2] = 32'h7FC00000;
    push_std(1);
    start_job();
    wait_cycle(11);
    chk("t3_err_in_qnt", 32'(err_level), 32'd0);
    wait_cycle(12);
    chk("t3_err_after_qnt", 32'(err_level), 32'd1);
    wait_done(40);
    chk("t3_err_sticky", 32'(err_level), 32'd1);

    // 4: clr during the OUT of index 1; error flag survives the abort.
    mem[0] = 32'h7FC00000;
    mem[2] = 32'h00000000;
    push_pair(0, 12, 1, 4);
    start_job();
    chk("t4_err_cleared", 32'(err_level), 32'd0);
    wait_cycle(8);
    chk("t4_valid", 32'(out_valid), 32'd1);
    chk("t4_idx", 32'(out_idx), 32'd1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_valid_off", 32'(out_valid), 32'd0);
    chk("t4_err_kept", 32'(err_level), 32'd1);
    chk("t4_addr", 32'(feat_rd_addr), 32'd0);
    repeat (3) @(negedge clk);
    chk("t4_still_idle", 32'(busy), 32'd0);

    // 5: fresh start from idx 0, with a stray start while busy.
    load_std();
    push_std(0);
    start_job();
    wait_cycle(6);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(40);
    repeat (3) @(negedge clk);
    chk("t5_no_restart", 32'(busy), 32'd0);

    // 6: asynchronous reset in the QNT of index 2.
    mem[0] = 32'h7FC00000;
    push_pair(0, 12, 1, 4);
    push_pair(1, 1, 1, 8);
    start_job();
    wait_cycle(11);
    chk("t6_in_qnt", 32'(q_en), 32'd1);
    #1 nrst = 1'b0;
    #1;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_q_en", 32'(q_en), 32'd0);
    chk("t6_err", 32'(err_level), 32'd0);
    chk("t6_q_value", q_value, 32'd0);
    chk("t6_out_idx", 32'(out_idx), 32'd0);
    chk("t6_out_level", 32'(out_level), 32'd0);
    chk("t6_done", 32'(done | out_valid | feat_rd_en), 32'd0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    repeat (4) @(negedge clk);
    chk("t6_idle_wait", 32'(busy), 32'd0);

    chk("pairs_left", 32'(exp_q.size()), 32'd0);
    chk("dones_left", 32'(done_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
